tx_pingpong_ctrl: RTL and testbench

//  Ping-pong scheduler for the 2-bank TX buffer between pkt_decode (writer) and usb_slavefifo (reader).

---
 rtl/tx_pingpong_if.sv | 34 +++
 rtl/tx_pingpong_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_tx_pingpong_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/tx_pingpong_if.sv
// Handshake bundle between the TX ping-pong scheduler (slave) and its writer/reader clients (master).
interface tx_pingpong_if #(
    parameter int unsigned ADDR_NBIT = 8
);
    // Writer side
    logic                 wr_req;
    logic                 wr_grant;
    logic                 wr_vd;
    logic                 wr_eop;
    logic                 wr_bank;
    logic [ADDR_NBIT-1:0] wr_addr;
    // Reader side
    logic                 rd_sop;
    logic                 rd_bank;
    logic [ADDR_NBIT:0]   rd_len;
    logic                 rd_done;
    // Status
    logic                 full;
    logic                 empty;
    logic                 ovf_err;
    logic                 tmo_err;

    modport master (
        output wr_req, wr_vd, wr_eop, rd_done,
        input  wr_grant, wr_bank, wr_addr, rd_sop, rd_bank, rd_len,
        input  full, empty, ovf_err, tmo_err
    );

    modport slave (
        input  wr_req, wr_vd, wr_eop, rd_done,
        output wr_grant, wr_bank, wr_addr, rd_sop, rd_bank, rd_len,
        output full, empty, ovf_err, tmo_err
    );
endinterface

// File: rtl/tx_pingpong_ctrl.sv
// Two-bank ping-pong scheduler for the TX buffer: grants banks to the writer, hands finished packets
// to the reader in write order. Optional reader watchdog enabled by `define TX_PP_TIMEOUT_EN.
module tx_pingpong_ctrl #(
    parameter int unsigned ADDR_NBIT   = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic         clk,
    input  logic         rst,
    tx_pingpong_if.slave bus
);

    typedef enum logic [1:0] {BkFree, BkFilling, BkReady, BkSending} bank_st_e;
    typedef enum logic {WIdle, WFill} wr_st_e;
    typedef enum logic {RIdle, RBusy} rd_st_e;

    localparam logic [ADDR_NBIT-1:0] AddrLast = '1;
    localparam logic [ADDR_NBIT-1:0] AddrOne  = 1;
    localparam logic [ADDR_NBIT:0]   LenOne   = 1;

    bank_st_e             bank_q [2];
    bank_st_e             bank_d [2];
    logic [ADDR_NBIT:0]   len_q  [2];
    logic [ADDR_NBIT:0]   len_d  [2];

    wr_st_e               wr_st_q, wr_st_d;
    logic                 wr_grant_q, wr_grant_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [ADDR_NBIT-1:0] wr_addr_q, wr_addr_d;

    rd_st_e               rd_st_q, rd_st_d;
    logic                 rd_sop_q, rd_sop_d;
    logic                 rd_bank_q, rd_bank_d;
    logic [ADDR_NBIT:0]   rd_len_q, rd_len_d;

    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 ovf_err_q, ovf_err_d;

`ifdef TX_PP_TIMEOUT_EN
    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYC - 1);

    logic [15:0]          tmo_cnt_q, tmo_cnt_d;
    logic                 tmo_err_q, tmo_err_d;
`endif

    // Writer and reader never move the same bank in one cycle: the writer only touches a
    // FREE/FILLING bank, the reader only a READY/SENDING one, so both updates can merge freely.
    always_comb begin
        bank_d     = bank_q;
        len_d      = len_q;
        wr_st_d    = wr_st_q;
        wr_grant_d = wr_grant_q;
        wr_bank_d  = wr_bank_q;
        wr_addr_d  = wr_addr_q;
        ovf_err_d  = ovf_err_q;
        rd_st_d    = rd_st_q;
        rd_sop_d   = 1'b0;
        rd_bank_d  = rd_bank_q;
        rd_len_d   = rd_len_q;
`ifdef TX_PP_TIMEOUT_EN
        tmo_cnt_d  = tmo_cnt_q;
        tmo_err_d  = 1'b0;
`endif

        unique case (wr_st_q)
            WIdle: begin
                if (bus.wr_req && (bank_q[wr_bank_q] == BkFree)) begin
                    wr_st_d           = WFill;
                    wr_grant_d        = 1'b1;
                    wr_addr_d         = '0;
                    bank_d[wr_bank_q] = BkFilling;
                end
            end
            WFill: begin
                if (bus.wr_vd) begin
                    // A beat landing on the last word closes the packet even without eop.
                    if (bus.wr_eop || (wr_addr_q == AddrLast)) begin
                        len_d[wr_bank_q]  = {1'b0, wr_addr_q} + LenOne;
                        bank_d[wr_bank_q] = BkReady;
                        wr_bank_d         = ~wr_bank_q;
                        wr_addr_d         = '0;
                        wr_grant_d        = 1'b0;
                        wr_st_d           = WIdle;
                        if (!bus.wr_eop) begin
                            ovf_err_d = 1'b1;
                        end
                    end else begin
                        wr_addr_d = wr_addr_q + AddrOne;
                    end
                end
            end
        endcase

        unique case (rd_st_q)
            RIdle: begin
                if (bank_q[rd_bank_q] == BkReady) begin
                    rd_sop_d          = 1'b1;
                    rd_len_d          = len_q[rd_bank_q];
                    bank_d[rd_bank_q] = BkSending;
                    rd_st_d           = RBusy;
`ifdef TX_PP_TIMEOUT_EN
                    tmo_cnt_d         = '0;
`endif
                end
            end
            RBusy: begin
                if (bus.rd_done) begin
                    bank_d[rd_bank_q] = BkFree;
                    rd_bank_d         = ~rd_bank_q;
                    rd_st_d           = RIdle;
`ifdef TX_PP_TIMEOUT_EN
                end else if (tmo_cnt_q == TmoLast) begin
                    bank_d[rd_bank_q] = BkFree;
                    rd_bank_d         = ~rd_bank_q;
                    rd_st_d           = RIdle;
                    tmo_err_d         = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
                end
            end
        endcase

        full_d  = (bank_d[0] != BkFree) && (bank_d[1] != BkFree);
        empty_d = (bank_d[0] == BkFree) && (bank_d[1] == BkFree);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0]  <= BkFree;
            bank_q[1]  <= BkFree;
            len_q[0]   <= '0;
            len_q[1]   <= '0;
            wr_st_q    <= WIdle;
            wr_grant_q <= 1'b0;
            wr_bank_q  <= 1'b0;
            wr_addr_q  <= '0;
            ovf_err_q  <= 1'b0;
            rd_st_q    <= RIdle;
            rd_sop_q   <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_len_q   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
`ifdef TX_PP_TIMEOUT_EN
            tmo_cnt_q  <= '0;
            tmo_err_q  <= 1'b0;
`endif
        end else begin
            bank_q[0]  <= bank_d[0];
            bank_q[1]  <= bank_d[1];
            len_q[0]   <= len_d[0];
            len_q[1]   <= len_d[1];
            wr_st_q    <= wr_st_d;
            wr_grant_q <= wr_grant_d;
            wr_bank_q  <= wr_bank_d;
            wr_addr_q  <= wr_addr_d;
            ovf_err_q  <= ovf_err_d;
            rd_st_q    <= rd_st_d;
            rd_sop_q   <= rd_sop_d;
            rd_bank_q  <= rd_bank_d;
            rd_len_q   <= rd_len_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
`ifdef TX_PP_TIMEOUT_EN
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_err_q  <= tmo_err_d;
`endif
        end
    end

    assign bus.wr_grant = wr_grant_q;
    assign bus.wr_bank  = wr_bank_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.rd_sop   = rd_sop_q;
    assign bus.rd_bank  = rd_bank_q;
    assign bus.rd_len   = rd_len_q;
    assign bus.full     = full_q;
    assign bus.empty    = empty_q;
    assign bus.ovf_err  = ovf_err_q;
`ifdef TX_PP_TIMEOUT_EN
    assign bus.tmo_err  = tmo_err_q;
`else
    assign bus.tmo_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tx_pingpong_ctrl.sv
// Randomized bench for tx_pingpong_ctrl against a packet-queue reference model.
module tb_tx_pingpong_ctrl;

    localparam int unsigned AddrNbit = 4;
    localparam int          Depth    = 1 << AddrNbit;
`ifdef TX_PP_TIMEOUT_EN
    localparam int unsigned TmoCyc   = 10;
    localparam bit          TmoEn    = 1'b1;
`else
    localparam int unsigned TmoCyc   = 65535;
    localparam bit          TmoEn    = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    tx_pingpong_if #(.ADDR_NBIT(AddrNbit)) bus ();

    tx_pingpong_ctrl #(
        .ADDR_NBIT  (AddrNbit),
        .TIMEOUT_CYC(TmoCyc)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: packets as a queue of lengths; bank numbers follow from packet counts.
    bit m_writing;
    int m_beats;
    int m_ready[$];
    bit m_sending;
    int m_wcnt;
    int m_rcnt;
    bit m_sop;
    int m_len;
    bit m_ovf;
    bit m_tmo;
    int m_wait;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_writing = 0;
        m_beats   = 0;
        m_ready.delete();
        m_sending = 0;
        m_wcnt    = 0;
        m_rcnt    = 0;
        m_sop     = 0;
        m_len     = 0;
        m_ovf     = 0;
        m_tmo     = 0;
        m_wait    = 0;
    endtask

    function automatic int model_occ();
        return int'(m_writing) + m_ready.size() + int'(m_sending);
    endfunction

    task automatic model_next(input bit req, input bit vd, input bit eop, input bit done);
        int occ;
        occ   = model_occ();
        m_sop = 0;
        m_tmo = 0;
        if (!m_sending) begin
            if (m_ready.size() > 0) begin
                m_len     = m_ready.pop_front();
                m_sop     = 1;
                m_sending = 1;
                m_wait    = 0;
            end
        end else if (done) begin
            m_sending = 0;
            m_rcnt++;
        end else if (TmoEn && (m_wait == int'(TmoCyc) - 1)) begin
            m_sending = 0;
            m_rcnt++;
            m_tmo = 1;
        end else begin
            m_wait++;
        end
        if (!m_writing) begin
            if (req && occ < 2) begin
                m_writing = 1;
                m_beats   = 0;
            end
        end else if (vd) begin
            if (eop || m_beats == Depth - 1) begin
                m_ready.push_back(m_beats + 1);
                if (!eop) m_ovf = 1;
                m_writing = 0;
                m_beats   = 0;
                m_wcnt++;
            end else begin
                m_beats++;
            end
        end
    endtask

    task automatic check_all();
        int occ;
        occ = model_occ();
        check_eq("wr_grant", bus.wr_grant, m_writing);
        check_eq("wr_addr",  bus.wr_addr,  m_beats);
        check_eq("wr_bank",  bus.wr_bank,  m_wcnt % 2);
        check_eq("rd_sop",   bus.rd_sop,   m_sop);
        check_eq("rd_bank",  bus.rd_bank,  m_rcnt % 2);
        check_eq("rd_len",   bus.rd_len,   m_len);
        check_eq("full",     bus.full,     occ == 2);
        check_eq("empty",    bus.empty,    occ == 0);
        check_eq("ovf_err",  bus.ovf_err,  m_ovf);
        check_eq("tmo_err",  bus.tmo_err,  m_tmo);
    endtask

    // Called 1 time unit after a rising edge; inputs stay stable across the next edge.
    task automatic step(input bit req, input bit vd, input bit eop, input bit done);
        bus.wr_req  = req;
        bus.wr_vd   = vd;
        bus.wr_eop  = eop;
        bus.rd_done = done;
        model_next(req, vd, eop, done);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic random_run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 6) == 0,
                 ($urandom % 4) == 0);
        end
    endtask

    initial begin
        bus.wr_req  = 1'b0;
        bus.wr_vd   = 1'b0;
        bus.wr_eop  = 1'b0;
        bus.rd_done = 1'b0;
        model_reset();
        #22;
        check_all();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 4-beat packet, then let the reader pick it up and release it
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);

        // 20 beats without eop: truncation at 16, trailing beats dropped
        step(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 1, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1);

        random_run(3000);

        // Reset in the middle of a fill
        step(0, 1, 1, 1);
        for (int i = 0; i < 50 && !m_writing; i++) step(1, 0, 0, 1);
        check_eq("drain_grant", bus.wr_grant, 1'b1);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        bus.wr_req  = 1'b0;
        bus.wr_vd   = 1'b0;
        bus.wr_eop  = 1'b0;
        bus.rd_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(0, 1, 1, 1);

        random_run(1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
